// File: rtl/cu_pkg.sv
// Shared types and constants for the control_unit sequencer: state encoding,
// opcodes, ALU/PC function codes and the packed control word.
package cu_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned REG_AW   = 3;
  localparam int unsigned FS_W     = 5;
  localparam int unsigned PS_W     = 2;
  localparam int unsigned OP_W     = 4;
  localparam int unsigned STATUS_W = 4;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned WAIT_W   = 2;
  localparam int unsigned STATUS_Z = 0;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h4;
  localparam logic [OP_W-1:0] OP_LD   = 4'h5;
  localparam logic [OP_W-1:0] OP_ST   = 4'h6;
  localparam logic [OP_W-1:0] OP_B    = 4'h7;
  localparam logic [OP_W-1:0] OP_CBZ  = 4'h8;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [FS_W-1:0] FS_PASSA = 5'b00000;
  localparam logic [FS_W-1:0] FS_ADD   = 5'b00010;
  localparam logic [FS_W-1:0] FS_SUB   = 5'b00101;
  localparam logic [FS_W-1:0] FS_AND   = 5'b01000;
  localparam logic [FS_W-1:0] FS_OR    = 5'b01001;

  localparam logic [PS_W-1:0] PS_HOLD = 2'b00;
  localparam logic [PS_W-1:0] PS_INC  = 2'b01;
  localparam logic [PS_W-1:0] PS_LOAD = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] aa;
    logic [REG_AW-1:0] ba;
    logic [REG_AW-1:0] da;
    logic              wr;
    logic [FS_W-1:0]   fs;
    logic              c0;
    logic [DATA_W-1:0] k;
    logic              bsel;
    logic              pcsel;
    logic [PS_W-1:0]   ps;
    logic              en_alu;
    logic              en_b;
    logic              en_pc;
    logic              rom_en;
    logic              en_address_alu;
    logic              enaddress_pc;
    logic              mr;
    logic              mw;
    logic              ir_en;
  } ctrl_t;

  function automatic logic [DATA_W-1:0] sext6(input logic [5:0] imm);
    return {{(DATA_W-6){imm[5]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext9(input logic [8:0] imm);
    return {{(DATA_W-9){1'b0}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext12(input logic [11:0] imm);
    return {{(DATA_W-12){1'b0}}, imm};
  endfunction

  // ALU function for the arithmetic/logic opcodes; ADDI shares the adder.
  function automatic logic [FS_W-1:0] fs_of_op(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB:  return FS_SUB;
      OP_AND:  return FS_AND;
      OP_OR:   return FS_OR;
      default: return FS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational control-word decoder: maps the sequencer state and the
// current instruction onto every datapath control input.
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  state_e            i_state,
  input  logic [DATA_W-1:0] i_ir,
  input  logic              i_zero,
  input  logic              i_fetch_go,
  input  logic              i_wait_last,
  output ctrl_t             o_ctrl_c
);

  localparam bit FETCH_LOADS_IR = (FETCH_WAIT == 0);

  logic [OP_W-1:0]   w_op;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_ra;
  logic [REG_AW-1:0] w_rb;
  logic [5:0]        w_imm6;
  logic [8:0]        w_imm9;
  logic [11:0]       w_imm12;

  assign w_op    = i_ir[15:12];
  assign w_rd    = i_ir[11:9];
  assign w_ra    = i_ir[8:6];
  assign w_rb    = i_ir[5:3];
  assign w_imm6  = i_ir[5:0];
  assign w_imm9  = i_ir[8:0];
  assign w_imm12 = i_ir[11:0];

  always_comb begin
    o_ctrl_c = '0;
    case (i_state)
      ST_FETCH: begin
        if (i_fetch_go) begin
          o_ctrl_c.enaddress_pc = 1'b1;
          o_ctrl_c.rom_en       = 1'b1;
          if (FETCH_LOADS_IR) begin
            o_ctrl_c.ir_en = 1'b1;
            o_ctrl_c.ps    = PS_INC;
          end
        end
      end
      ST_WAIT: begin
        o_ctrl_c.enaddress_pc = 1'b1;
        o_ctrl_c.rom_en       = 1'b1;
        if (i_wait_last) begin
          o_ctrl_c.ir_en = 1'b1;
          o_ctrl_c.ps    = PS_INC;
        end
      end
      ST_EXEC: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
            o_ctrl_c.aa     = w_ra;
            o_ctrl_c.da     = w_rd;
            o_ctrl_c.fs     = fs_of_op(w_op);
            o_ctrl_c.c0     = (w_op == OP_SUB);
            o_ctrl_c.en_alu = 1'b1;
            o_ctrl_c.wr     = 1'b1;
            if (w_op == OP_ADDI) begin
              o_ctrl_c.bsel = 1'b1;
              o_ctrl_c.k    = sext6(w_imm6);
            end else begin
              o_ctrl_c.ba = w_rb;
            end
          end
          OP_LD: begin
            o_ctrl_c.aa             = w_ra;
            o_ctrl_c.bsel           = 1'b1;
            o_ctrl_c.k              = sext6(w_imm6);
            o_ctrl_c.fs             = FS_ADD;
            o_ctrl_c.en_address_alu = 1'b1;
            o_ctrl_c.mr             = 1'b1;
          end
          // Address comes from the ALU (ra + K) while B drives store data.
          OP_ST: begin
            o_ctrl_c.aa             = w_ra;
            o_ctrl_c.ba             = w_rd;
            o_ctrl_c.bsel           = 1'b1;
            o_ctrl_c.k              = sext6(w_imm6);
            o_ctrl_c.fs             = FS_ADD;
            o_ctrl_c.en_address_alu = 1'b1;
            o_ctrl_c.en_b           = 1'b1;
            o_ctrl_c.mw             = 1'b1;
          end
          OP_B: begin
            o_ctrl_c.pcsel = 1'b1;
            o_ctrl_c.k     = zext12(w_imm12);
            o_ctrl_c.ps    = PS_LOAD;
          end
          OP_CBZ: begin
            o_ctrl_c.aa = w_rd;
            o_ctrl_c.fs = FS_PASSA;
            if (i_zero) begin
              o_ctrl_c.pcsel = 1'b1;
              o_ctrl_c.k     = zext9(w_imm9);
              o_ctrl_c.ps    = PS_LOAD;
            end else begin
              o_ctrl_c.ps = PS_HOLD;
            end
          end
          default: ;
        endcase
      end
      // RAM owns the data bus; the ALU keeps the load address on the address bus.
      ST_MEM: begin
        o_ctrl_c.aa             = w_ra;
        o_ctrl_c.bsel           = 1'b1;
        o_ctrl_c.k              = sext6(w_imm6);
        o_ctrl_c.fs             = FS_ADD;
        o_ctrl_c.en_address_alu = 1'b1;
        o_ctrl_c.mr             = 1'b1;
        o_ctrl_c.da             = w_rd;
        o_ctrl_c.wr             = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Optional build macro CU_SINGLE_STEP_EN adds the step input for single-stepping.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned FETCH_WAIT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   IR_OUT,
  input  logic [STATUS_W-1:0] status,
`ifdef CU_SINGLE_STEP_EN
  input  logic                step,
`endif
  output logic [REG_AW-1:0]   AA,
  output logic [REG_AW-1:0]   BA,
  output logic [REG_AW-1:0]   DA,
  output logic                WR,
  output logic [FS_W-1:0]     FS,
  output logic                C0,
  output logic [DATA_W-1:0]   K,
  output logic                BSEL,
  output logic                PCSEL,
  output logic [PS_W-1:0]     PS,
  output logic                EN_ALU,
  output logic                EN_B,
  output logic                EN_PC,
  output logic                ROM_EN,
  output logic                EN_ADDRESS_ALU,
  output logic                ENADDRESS_PC,
  output logic                MR,
  output logic                MW,
  output logic                IR_EN,
  output logic                halted,
  output logic [STATE_W-1:0]  state_VIZ
);

  localparam int unsigned WAIT_LAST = (FETCH_WAIT == 0) ? 0 : FETCH_WAIT - 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_active;
  logic              w_wait_last;
  logic              w_fetch_go;
  ctrl_t             w_ctrl;
  ctrl_t             w_ctrl_g;
  logic [2:0]        w_unused_status;

  assign w_unused_status = status[STATUS_W-1:1];
  assign w_wait_last     = (r_wait_cnt == WAIT_W'(WAIT_LAST));

`ifdef CU_SINGLE_STEP_EN
  logic r_step_go;

  // A sampled step pulse releases exactly one fetch; cleared once the IR loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step_go <= 1'b0;
    end else if (r_active && w_ctrl.ir_en) begin
      r_step_go <= 1'b0;
    end else if (r_active && (r_state == ST_FETCH) && step) begin
      r_step_go <= 1'b1;
    end
  end

  assign w_fetch_go = r_step_go;
`else
  assign w_fetch_go = 1'b1;
`endif

  // Sequencing starts on the first edge after reset releases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_active <= 1'b0;
    end else begin
      r_active <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    if (r_active) begin
      case (r_state)
        ST_FETCH: begin
          if (w_fetch_go) begin
            if (FETCH_WAIT == 0) begin
              w_state_nxt = ST_DECODE;
            end else begin
              w_state_nxt = ST_WAIT;
              w_wait_nxt  = '0;
            end
          end
        end
        ST_WAIT: begin
          if (w_wait_last) begin
            w_state_nxt = ST_DECODE;
            w_wait_nxt  = '0;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
        ST_DECODE: w_state_nxt = (IR_OUT[15:12] == OP_HALT) ? ST_HALT : ST_EXEC;
        ST_EXEC:   w_state_nxt = (IR_OUT[15:12] == OP_LD) ? ST_MEM : ST_FETCH;
        ST_MEM:    w_state_nxt = ST_FETCH;
        ST_HALT:   w_state_nxt = ST_HALT;
        default:   w_state_nxt = ST_FETCH;
      endcase
    end
  end

  cu_decode #(
    .FETCH_WAIT (FETCH_WAIT)
  ) u_decode (
    .i_state     (r_state),
    .i_ir        (IR_OUT),
    .i_zero      (status[STATUS_Z]),
    .i_fetch_go  (w_fetch_go),
    .i_wait_last (w_wait_last),
    .o_ctrl_c    (w_ctrl)
  );

  // Every strobe is forced low while reset is asserted or not yet sequencing.
  assign w_ctrl_g = r_active ? w_ctrl : '0;

  assign AA             = w_ctrl_g.aa;
  assign BA             = w_ctrl_g.ba;
  assign DA             = w_ctrl_g.da;
  assign WR             = w_ctrl_g.wr;
  assign FS             = w_ctrl_g.fs;
  assign C0             = w_ctrl_g.c0;
  assign K              = w_ctrl_g.k;
  assign BSEL           = w_ctrl_g.bsel;
  assign PCSEL          = w_ctrl_g.pcsel;
  assign PS             = w_ctrl_g.ps;
  assign EN_ALU         = w_ctrl_g.en_alu;
  assign EN_B           = w_ctrl_g.en_b;
  assign EN_PC          = w_ctrl_g.en_pc;
  assign ROM_EN         = w_ctrl_g.rom_en;
  assign EN_ADDRESS_ALU = w_ctrl_g.en_address_alu;
  assign ENADDRESS_PC   = w_ctrl_g.enaddress_pc;
  assign MR             = w_ctrl_g.mr;
  assign MW             = w_ctrl_g.mw;
  assign IR_EN          = w_ctrl_g.ir_en;
  assign halted         = r_active && (r_state == ST_HALT);
  assign state_VIZ      = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one instance with FETCH_WAIT=0 runs the
// instruction scenarios, a second with FETCH_WAIT=2 covers the ROM wait path.
module tb_control_unit;
  import cu_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] ir;
  logic [3:0]  status;
`ifdef CU_SINGLE_STEP_EN
  logic        step;
`endif
  int checks;
  int failures;

  logic [2:0]  AA_0, BA_0, DA_0, AA_2, BA_2, DA_2;
  logic        WR_0, C0_0, BSEL_0, PCSEL_0, WR_2, C0_2, BSEL_2, PCSEL_2;
  logic [4:0]  FS_0, FS_2;
  logic [15:0] K_0, K_2;
  logic [1:0]  PS_0, PS_2;
  logic        EN_ALU_0, EN_B_0, EN_PC_0, ROM_EN_0, EAA_0, EAP_0, MR_0, MW_0, IR_EN_0, halted_0;
  logic        EN_ALU_2, EN_B_2, EN_PC_2, ROM_EN_2, EAA_2, EAP_2, MR_2, MW_2, IR_EN_2, halted_2;
  logic [2:0]  st_0, st_2;

  logic [45:0] all_0, all_2;
  logic [9:0]  strb_0;
  assign all_0 = {AA_0, BA_0, DA_0, WR_0, FS_0, C0_0, K_0, BSEL_0, PCSEL_0, PS_0, EN_ALU_0,
                  EN_B_0, EN_PC_0, ROM_EN_0, EAA_0, EAP_0, MR_0, MW_0, IR_EN_0, halted_0};
  assign all_2 = {AA_2, BA_2, DA_2, WR_2, FS_2, C0_2, K_2, BSEL_2, PCSEL_2, PS_2, EN_ALU_2,
                  EN_B_2, EN_PC_2, ROM_EN_2, EAA_2, EAP_2, MR_2, MW_2, IR_EN_2, halted_2};
  assign strb_0 = {WR_0, EN_ALU_0, EN_B_0, EN_PC_0, ROM_EN_0, EAA_0, EAP_0, MR_0, MW_0, IR_EN_0};

  control_unit #(.FETCH_WAIT(0)) dut0 (
    .clk(clk), .reset(reset), .IR_OUT(ir), .status(status),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .AA(AA_0), .BA(BA_0), .DA(DA_0), .WR(WR_0), .FS(FS_0), .C0(C0_0), .K(K_0),
    .BSEL(BSEL_0), .PCSEL(PCSEL_0), .PS(PS_0), .EN_ALU(EN_ALU_0), .EN_B(EN_B_0),
    .EN_PC(EN_PC_0), .ROM_EN(ROM_EN_0), .EN_ADDRESS_ALU(EAA_0), .ENADDRESS_PC(EAP_0),
    .MR(MR_0), .MW(MW_0), .IR_EN(IR_EN_0), .halted(halted_0), .state_VIZ(st_0)
  );

  control_unit #(.FETCH_WAIT(2)) dut2 (
    .clk(clk), .reset(reset), .IR_OUT(ir), .status(status),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .AA(AA_2), .BA(BA_2), .DA(DA_2), .WR(WR_2), .FS(FS_2), .C0(C0_2), .K(K_2),
    .BSEL(BSEL_2), .PCSEL(PCSEL_2), .PS(PS_2), .EN_ALU(EN_ALU_2), .EN_B(EN_B_2),
    .EN_PC(EN_PC_2), .ROM_EN(ROM_EN_2), .EN_ADDRESS_ALU(EAA_2), .ENADDRESS_PC(EAP_2),
    .MR(MR_2), .MW(MW_2), .IR_EN(IR_EN_2), .halted(halted_2), .state_VIZ(st_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves both instances in their first active FETCH cycle.
  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ir = 16'h1298;
    tick();
    tick();
    checks++; if (all_0 !== 46'd0) begin failures++; $display("FAIL reset_outs0 got=%h exp=0", all_0); end
    checks++; if (all_2 !== 46'd0) begin failures++; $display("FAIL reset_outs2 got=%h exp=0", all_2); end
    checks++; if (st_0 !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", st_0); end
    reset = 1'b1;
    #1;
    checks++; if (all_0 !== 46'd0) begin failures++; $display("FAIL pre_edge_outs got=%h exp=0", all_0); end
    tick();
    checks++; if ({st_0, EAP_0, ROM_EN_0, IR_EN_0, PS_0} !== {3'd0, 1'b1, 1'b1, 1'b1, 2'b01})
      begin failures++; $display("FAIL fetch0 got=%b exp=%b", {st_0, EAP_0, ROM_EN_0, IR_EN_0, PS_0}, 8'b000_1_1_1_01); end
    checks++; if ({EAP_2, ROM_EN_2, IR_EN_2, PS_2} !== {1'b1, 1'b1, 1'b0, 2'b00})
      begin failures++; $display("FAIL fetch2 got=%b exp=%b", {EAP_2, ROM_EN_2, IR_EN_2, PS_2}, 5'b1_1_0_00); end
  endtask

  task automatic test_sub();
    ir = 16'h1298;
    tick();
    checks++; if ({st_0, EN_ALU_0, EN_B_0, EN_PC_0, ROM_EN_0, WR_0} !== {3'd2, 5'b0})
      begin failures++; $display("FAIL sub_decode got=%b exp=%b", {st_0, EN_ALU_0, EN_B_0, EN_PC_0, ROM_EN_0, WR_0}, 8'b010_00000); end
    tick();
    checks++; if ({st_0, AA_0, BA_0, DA_0, C0_0, EN_ALU_0, WR_0, BSEL_0} !== {3'd3, 3'd2, 3'd3, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0})
      begin failures++; $display("FAIL sub_exec got=%b", {st_0, AA_0, BA_0, DA_0, C0_0, EN_ALU_0, WR_0, BSEL_0}); end
    checks++; if (FS_0 !== FS_SUB) begin failures++; $display("FAIL sub_fs got=%b exp=%b", FS_0, FS_SUB); end
    tick();
    checks++; if ({st_0, ROM_EN_0, WR_0} !== {3'd0, 1'b1, 1'b0})
      begin failures++; $display("FAIL sub_next_fetch got=%b exp=00010", {st_0, ROM_EN_0, WR_0}); end
  endtask

  task automatic test_ld();
    ir = 16'h5287;
    tick();
    tick();
    checks++; if ({st_0, AA_0, EAA_0, MR_0, BSEL_0, K_0, WR_0, EN_ALU_0, EAP_0} !== {3'd3, 3'd2, 1'b1, 1'b1, 1'b1, 16'h0007, 3'b000})
      begin failures++; $display("FAIL ld_exec got=%h", {st_0, AA_0, EAA_0, MR_0, BSEL_0, K_0, WR_0, EN_ALU_0, EAP_0}); end
    checks++; if (FS_0 !== FS_ADD) begin failures++; $display("FAIL ld_fs got=%b exp=%b", FS_0, FS_ADD); end
    tick();
    checks++; if ({st_0, WR_0, DA_0, MR_0, EAA_0, EN_ALU_0, EN_B_0, ROM_EN_0} !== {3'd4, 1'b1, 3'd1, 1'b1, 1'b1, 3'b000})
      begin failures++; $display("FAIL ld_mem got=%b", {st_0, WR_0, DA_0, MR_0, EAA_0, EN_ALU_0, EN_B_0, ROM_EN_0}); end
    tick();
    checks++; if (st_0 !== 3'd0) begin failures++; $display("FAIL ld_next_fetch got=%0d exp=0", st_0); end
  endtask

  task automatic test_addi();
    ir = 16'h473F;
    tick();
    tick();
    checks++; if ({AA_0, DA_0, BSEL_0, K_0, C0_0, EN_ALU_0, WR_0} !== {3'd4, 3'd3, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1})
      begin failures++; $display("FAIL addi_exec got=%h", {AA_0, DA_0, BSEL_0, K_0, C0_0, EN_ALU_0, WR_0}); end
    checks++; if (FS_0 !== FS_ADD) begin failures++; $display("FAIL addi_fs got=%b exp=%b", FS_0, FS_ADD); end
    tick();
  endtask

  task automatic test_st();
    ir = 16'h6A60;
    tick();
    tick();
    checks++; if ({AA_0, BA_0, K_0, EN_B_0, EAA_0, MW_0, WR_0, EN_ALU_0, MR_0} !== {3'd1, 3'd5, 16'hFFE0, 1'b1, 1'b1, 1'b1, 3'b000})
      begin failures++; $display("FAIL st_exec got=%h", {AA_0, BA_0, K_0, EN_B_0, EAA_0, MW_0, WR_0, EN_ALU_0, MR_0}); end
    tick();
    checks++; if (st_0 !== 3'd0) begin failures++; $display("FAIL st_next_fetch got=%0d exp=0", st_0); end
  endtask

  task automatic test_branch();
    ir = 16'h7ABC;
    tick();
    tick();
    checks++; if ({PCSEL_0, PS_0, K_0, WR_0, EN_ALU_0} !== {1'b1, 2'b10, 16'h0ABC, 2'b00})
      begin failures++; $display("FAIL b_exec got=%h", {PCSEL_0, PS_0, K_0, WR_0, EN_ALU_0}); end
    tick();
  endtask

  task automatic test_cbz();
    ir = 16'h85F5;
    status = 4'b0001;
    tick();
    tick();
    checks++; if ({AA_0, PCSEL_0, PS_0, K_0} !== {3'd2, 1'b1, 2'b10, 16'h01F5})
      begin failures++; $display("FAIL cbz_taken got=%h", {AA_0, PCSEL_0, PS_0, K_0}); end
    checks++; if (FS_0 !== FS_PASSA) begin failures++; $display("FAIL cbz_fs got=%b exp=%b", FS_0, FS_PASSA); end
    tick();
    status = 4'b1110;
    tick();
    tick();
    checks++; if ({AA_0, PCSEL_0, PS_0} !== {3'd2, 1'b0, 2'b00})
      begin failures++; $display("FAIL cbz_not_taken got=%b exp=010000", {AA_0, PCSEL_0, PS_0}); end
    tick();
    status = 4'b0000;
  endtask

  task automatic test_nop();
    ir = 16'h9FFF;
    tick();
    tick();
    checks++; if ({st_0, strb_0, PS_0} !== {3'd3, 10'd0, 2'b00})
      begin failures++; $display("FAIL nop_exec got=%b", {st_0, strb_0, PS_0}); end
    tick();
    checks++; if (st_0 !== 3'd0) begin failures++; $display("FAIL nop_next_fetch got=%0d exp=0", st_0); end
  endtask

  task automatic test_halt();
    ir = 16'hF000;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if ({halted_0, st_0, strb_0, PS_0} !== {1'b1, 3'd5, 10'd0, 2'b00})
        begin failures++; $display("FAIL halt_hold cyc=%0d got=%b", i, {halted_0, st_0, strb_0, PS_0}); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ir = 16'h6A60;
    tick();
    tick();
    checks++; if (MW_0 !== 1'b1) begin failures++; $display("FAIL mid_pre_mw got=%b exp=1", MW_0); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (all_0 !== 46'd0) begin failures++; $display("FAIL mid_reset_async got=%h exp=0", all_0); end
    tick();
    checks++; if ({st_0, WR_0, MW_0} !== 5'd0) begin failures++; $display("FAIL mid_reset_hold got=%b exp=0", {st_0, WR_0, MW_0}); end
    reset = 1'b1;
  endtask

  task automatic test_wait();
    logic [2:0] exp_st [6];
    logic [3:0] exp_sig [6];
    logic       bus_ok;
    exp_st  = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_sig = '{4'b1000, 4'b1000, 4'b1110, 4'b0000, 4'b0001, 4'b1000};
    ir = 16'h1298;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      checks++; if ({st_2, ROM_EN_2, IR_EN_2, PS_2 == 2'b01, EN_ALU_2} !== {exp_st[i], exp_sig[i]})
        begin failures++; $display("FAIL wait_seq cyc=%0d got=%b exp=%b", i, {st_2, ROM_EN_2, IR_EN_2, PS_2 == 2'b01, EN_ALU_2}, {exp_st[i], exp_sig[i]}); end
      bus_ok = ($countones({EN_ALU_2, EN_B_2, EN_PC_2, ROM_EN_2, MR_2 && (st_2 == 3'd4)}) <= 1) && !(EAA_2 && EAP_2);
      checks++; if (bus_ok !== 1'b1) begin failures++; $display("FAIL wait_arbitration cyc=%0d got=%b exp=1", i, bus_ok); end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    ir       = 16'h0000;
    status   = 4'b0000;
`ifdef CU_SINGLE_STEP_EN
    step     = 1'b1;
`endif
    test_reset();
    test_sub();
    test_ld();
    test_addi();
    test_st();
    test_branch();
    test_cbz();
    test_nop();
    test_halt();
    test_reset_mid();
    test_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
